fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FETCH_MISALIGN_CHECK_EN adds the FS_FAULT state used for misaligned redirect targets.
package core;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1
  } fetch_state_t;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// In-order instruction buffer: registered head, flush beats push, push+pop allowed when full.
module fetch_fifo
  import core::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != FULL_CNT) || do_pop);
    count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    if (flush_i) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        // When full, a simultaneous push overwrites the slot being popped.
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data_i;
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, credit-limited imem requests, stale-response discard on redirect.
// Optional macro FETCH_MISALIGN_CHECK_EN turns misaligned redirects into fault entries.
module fetch_unit
  import core::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         instr_valid_o,
  input  logic         instr_ready_i,
  output logic [31:0]  instruction_o,
  output logic [31:0]  pc_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic         fetch_fault_o,
`endif
  output fetch_state_t fsm_state_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d, discard_q, discard_d, fifo_count;
  logic [CNT_W:0]   in_use;
  logic             pop, grant, rsp_ok, push, flush, fifo_valid;
  fetch_entry_t     push_data, head;
  logic [31:0]      redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic             misaligned;
  logic             fault_pend_q, fault_pend_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  assign redir_pc   = redirect_pc_i;
  assign misaligned = |redirect_pc_i[1:0];
`else
  assign redir_pc   = {redirect_pc_i[31:2], 2'b00};
`endif

  // Credit: every in-flight request must have a FIFO slot once the head pops.
  assign pop        = fifo_valid & instr_ready_i;
  assign in_use     = {1'b0, outst_q} + {1'b0, fifo_count} - (CNT_W+1)'(pop);
  assign imem_req_o = (state_q == FS_RUN) && (in_use < (CNT_W+1)'(BUF_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign grant      = imem_req_o & imem_gnt_i;
  assign rsp_ok     = imem_rvalid_i & (outst_q != '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CNT_W'(grant) - CNT_W'(rsp_ok);
    discard_d  = discard_q;
    flush      = 1'b0;
    push       = 1'b0;
    push_data  = '{instr: imem_rdata_i, pc: resp_pc_q, fault: 1'b0};
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_pend_d = 1'b0;
    fault_pc_d   = fault_pc_q;
`endif
    if (state_q == FS_IDLE) state_d = FS_RUN;
    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp_ok) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CNT_W'(1);
      end else begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
      end
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    // In FS_FAULT every response is being discarded, so this push never collides.
    if (fault_pend_q) begin
      push      = 1'b1;
      push_data = '{instr: NOP_INSTR, pc: fault_pc_q, fault: 1'b1};
    end
`endif
    // Everything still in flight after this edge belongs to the old stream.
    if (redirect_i) begin
      flush      = 1'b1;
      push       = 1'b0;
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      discard_d  = outst_d;
      state_d    = FS_RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (misaligned) begin
        state_d      = FS_FAULT;
        fault_pend_d = 1'b1;
        fault_pc_d   = redirect_pc_i;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_q <= fault_pend_d;
      fault_pc_q   <= fault_pc_d;
`endif
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign instr_valid_o = fifo_valid;
  assign instruction_o = head.instr;
  assign pc_o          = head.pc;
  assign fsm_state_o   = state_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault_o = head.fault;
`else
  logic unused_fault;
  assign unused_fault = head.fault;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random imem/decoder/redirect traffic against a stream-level model.
// Honours FETCH_MISALIGN_CHECK_EN for the fault-entry scenarios.
module tb_fetch_unit;
  import core::*;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic         clk, rst;
  logic         imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0]  imem_addr_o, imem_rdata_i;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  logic         instr_valid_o, instr_ready_i;
  logic [31:0]  instruction_o, pc_o;
  fetch_state_t fsm_state_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic         fetch_fault_o;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_fault_o (fetch_fault_o),
`endif
    .fsm_state_o   (fsm_state_o)
  );

  // Expected decoder-visible stream: {fault, pc}; instruction is derived from pc.
  logic [32:0] exp_q[$];
  logic [31:0] pend_addr_q[$];
  int          pend_due_q[$];
  logic [31:0] exp_addr;
  int          n_cmp = 0, n_bad = 0, cyc = 0, rel_cyc = 0;
  int          first_valid = -1, pop_cnt = 0, spurious = 0;
  bit          no_req, redir_prev, hold_prev, want_same;
  logic [31:0] prev_pc, prev_instr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic evaluate(input int kmax);
    logic [32:0] e;
    logic [31:0] tgt;
    if (instr_valid_o && first_valid < 0) first_valid = cyc - rel_cyc;
    if (redir_prev) begin
      check_eq("valid_after_redirect", instr_valid_o, 0);
    end else if (hold_prev) begin
      check_eq("hold_pc", pc_o, prev_pc);
      check_eq("hold_instr", instruction_o, prev_instr);
    end
    if (instr_valid_o && instr_ready_i) begin
      pop_cnt++;
      check_eq("pop_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("head_pc", pc_o, e[31:0]);
        check_eq("head_instr", instruction_o, e[32] ? NOP_INSTR : word_of(e[31:0]));
`ifdef FETCH_MISALIGN_CHECK_EN
        check_eq("head_fault", fetch_fault_o, e[32]);
`endif
      end
    end
    if (imem_req_o) begin
      check_eq("req_allowed", no_req, 0);
      check_eq("req_addr", imem_addr_o, exp_addr);
    end
    if (imem_req_o && imem_gnt_i) begin
      check_eq("credit", exp_q.size() < BUF_DEPTH, 1);
      pend_addr_q.push_back(imem_addr_o);
      pend_due_q.push_back(cyc + int'($urandom_range(kmax, 1)));
      if (!redirect_i) begin
        exp_q.push_back({1'b0, imem_addr_o});
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (redirect_i) begin
      if (want_same) check_eq("same_cycle_setup", imem_req_o & imem_gnt_i & imem_rvalid_i, 1);
      exp_q.delete();
      tgt = redirect_pc_i;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        exp_q.push_back({1'b1, tgt});
        no_req = 1'b1;
      end else begin
        exp_addr = tgt;
        no_req   = 1'b0;
      end
`else
      exp_addr = {tgt[31:2], 2'b00};
      no_req   = 1'b0;
`endif
    end
    hold_prev  = instr_valid_o & ~instr_ready_i;
    prev_pc    = pc_o;
    prev_instr = instruction_o;
    redir_prev = redirect_i;
  endtask

  task automatic cycle(input bit redir, input logic [31:0] tgt, input int rdy_pct,
                       input int gnt_pct, input int rv_pct, input int kmax);
    redirect_i    = redir;
    redirect_pc_i = tgt;
    instr_ready_i = ($urandom_range(99) < rdy_pct);
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (spurious > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      spurious--;
    end else if (pend_addr_q.size() > 0 && pend_due_q[0] <= cyc && $urandom_range(99) < rv_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word_of(pend_addr_q.pop_front());
      pend_due_q.delete(0);
    end
    @(negedge clk);
    evaluate(kmax);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    #1;
    check_eq("rst_req", imem_req_o, 0);
    check_eq("rst_addr", imem_addr_o, RESET_PC);
    check_eq("rst_valid", instr_valid_o, 0);
    check_eq("rst_pc", pc_o, 0);
    check_eq("rst_instr", instruction_o, 0);
    check_eq("rst_state", fsm_state_o, FS_IDLE);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("rst_fault", fetch_fault_o, 0);
`endif
    exp_q.delete();
    pend_addr_q.delete();
    pend_due_q.delete();
    exp_addr   = RESET_PC;
    no_req     = 1'b0;
    redir_prev = 1'b0;
    hold_prev  = 1'b0;
    want_same  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    rel_cyc     = cyc;
    first_valid = -1;
    pop_cnt     = 0;
    #1;
    check_eq("idle_no_req", imem_req_o, 0);
  endtask

  task automatic wait_head(input logic [31:0] tgt, input string tag);
    int n;
    n = 0;
    while (!instr_valid_o && n < 20) begin
      cycle(1'b0, '0, 0, 100, 100, 1);
      n++;
    end
    check_eq(tag, {instr_valid_o, pc_o}, {1'b1, tgt});
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r;
    logic [31:0] t;
    int          n;
    rst           = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Streaming from reset: grant every cycle, k = 1, decoder always ready.
    for (int i = 0; i < 13; i++) cycle(1'b0, '0, 100, 100, 100, 1);
    check_eq("first_valid_cycle", first_valid, 3);
    check_eq("steady_pops", pop_cnt, 10);

    // Decoder stall, then release.
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 0, 100, 100, 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 100, 100, 100, 1);

    // Two requests in flight, then redirect.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 100, 100, 0, 1);
    check_eq("outstanding_before_redirect", pend_addr_q.size(), 2);
    cycle(1'b1, 32'h0000_0100, 100, 100, 0, 1);
    wait_head(32'h0000_0100, "redirect_head");

    // Redirect coinciding with a grant and a response.
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 100, 100, 100, 1);
    want_same = 1'b1;
    cycle(1'b1, 32'h0000_2000, 100, 100, 100, 1);
    want_same = 1'b0;
    wait_head(32'h0000_2000, "same_cycle_head");

    // PC wrap.
    cycle(1'b1, 32'hFFFF_FFFC, 100, 100, 100, 1);
    wait_head(32'hFFFF_FFFC, "wrap_first_head");
    cycle(1'b0, '0, 100, 100, 100, 1);
    check_eq("wrap_head", {instr_valid_o, pc_o}, {1'b1, 32'h0});

    // Misaligned redirect target.
`ifdef FETCH_MISALIGN_CHECK_EN
    cycle(1'b1, 32'h0000_0102, 0, 100, 100, 1);
    wait_head(32'h0000_0102, "fault_head");
    check_eq("fault_flag", fetch_fault_o, 1);
    check_eq("fault_instr", instruction_o, NOP_INSTR);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 100, 100, 100, 1);
    check_eq("fault_state", fsm_state_o, FS_FAULT);
    cycle(1'b1, 32'h0000_0200, 100, 100, 100, 1);
    wait_head(32'h0000_0200, "fault_exit_head");
`else
    cycle(1'b1, 32'h0000_0102, 100, 100, 100, 1);
    wait_head(32'h0000_0100, "align_forced_head");
`endif

    // Random traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        do_reset();
        spurious = 2;
      end
      r = ($urandom_range(99) < 4);
      t = $urandom;
      if ($urandom_range(3) == 0) t[31:4] = '1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if ($urandom_range(99) >= 15) t[1:0] = 2'b00;
`endif
      cycle(r, t, 70, 60, 60, 4);
    end

    // Drain: no new grants, deliver everything, consume everything.
    n = 0;
    while ((exp_q.size() != 0 || pend_addr_q.size() != 0) && n < 200) begin
      cycle(1'b0, '0, 100, 0, 100, 1);
      n++;
    end
    check_eq("drain_done", exp_q.size(), 0);
    check_eq("drain_valid", instr_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
